// File: rtl/arith_pkg.sv
// ============================================================================
// Module : arith_pkg
// Brief  : Shared types and helpers for the sequential arithmetic datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/int_divider_div_step.sv
// ============================================================================
// Module : div_step
// Brief  : Combinational single-bit restoring divide stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // A restored remainder is always below d, so WIDTH bits hold it exactly.
    always_comb begin
        w_shift  = {rem, q_msb};
        w_trial  = w_shift - {1'b0, d};
        q_bit    = ~w_trial[WIDTH];
        rem_next = q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/int_divider.sv
// ============================================================================
// Module : int_divider
// Brief  : Sequential unsigned restoring divider, one quotient bit per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module int_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int            C_CW   = cnt_width(WIDTH);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_d;
    logic [WIDTH-1:0]  r_r;
    logic [C_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  w_r_next;
    logic              w_qbit;
    logic              w_accept;
    logic              w_last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (r_r),
        .q_msb    (r_q[WIDTH-1]),
        .d        (r_d),
        .rem_next (w_r_next),
        .q_bit    (w_qbit)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                if (r_cnt == C_LAST) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Result registers only move on the completion edge so RUN shows the prior result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_q         <= dividend;
            r_d         <= divisor;
            r_r         <= '0;
            r_cnt       <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (r_state == RUN) begin
            r_q   <= {r_q[WIDTH-2:0], w_qbit};
            r_r   <= w_r_next;
            r_cnt <= r_cnt + C_CW'(1);
            if (w_last) begin
                quotient    <= {r_q[WIDTH-2:0], w_qbit};
                remainder   <= w_r_next;
                busy        <= 1'b0;
                done        <= 1'b1;
                div_by_zero <= (r_d == '0);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_int_divider.sv
// ============================================================================
// Module : tb_int_divider
// Brief  : Self-checking bench for int_divider with a result scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_int_divider;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } exp_t;

    exp_t             sb[$];
    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-1:0] last_q = '0;
    logic [WIDTH-1:0] last_r = '0;

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one start cycle and record the reference result.
    task automatic launch(input int a, input int b);
        exp_t e;
        e.a = WIDTH'(a);
        e.b = WIDTH'(b);
        if (b == 0) begin
            e.q   = '1;
            e.r   = WIDTH'(a);
            e.dbz = 1'b1;
        end else begin
            e.q   = WIDTH'(a / b);
            e.r   = WIDTH'(a % b);
            e.dbz = 1'b0;
        end
        @(negedge clk);
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after the accept edge with `done_wait` RUN negedges already consumed.
    task automatic finish(input string tag, input int done_wait);
        exp_t e;
        for (int i = done_wait; i < WIDTH - 1; i++) begin
            @(negedge clk);
            check({tag, ".busy_run"}, int'(busy), 1);
            check({tag, ".done_run"}, int'(done), 0);
            check({tag, ".q_hold"}, int'(quotient), int'(last_q));
            check({tag, ".r_hold"}, int'(remainder), int'(last_r));
        end
        @(negedge clk);
        check({tag, ".done"}, int'(done), 1);
        check({tag, ".busy"}, int'(busy), 0);
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, ".quotient"}, int'(quotient), int'(e.q));
            check({tag, ".remainder"}, int'(remainder), int'(e.r));
            check({tag, ".dbz"}, int'(div_by_zero), int'(e.dbz));
            if (e.b != 0) begin
                check({tag, ".identity"}, int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
                check({tag, ".r_lt_d"}, int'(remainder < e.b), 1);
            end
            last_q = e.q;
            last_r = e.r;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst.quotient", int'(quotient), 0);
        check("rst.remainder", int'(remainder), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.dbz", int'(div_by_zero), 0);
        reset_n = 1'b1;

        launch(15, 4);  finish("d15_4", 0);
        launch(0, 3);   finish("d0_3", 0);
        launch(7, 7);   finish("d7_7", 0);
        launch(15, 1);  finish("d15_1", 0);
        launch(3, 15);  finish("d3_15", 0);
        launch(5, 0);   finish("d5_0", 0);

        // start pulsed on the second RUN edge must be ignored
        launch(9, 2);
        @(negedge clk);
        check("mid.q_hold", int'(quotient), int'(last_q));
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid.busy", int'(busy), 1);
        finish("mid9_2", 2);
        @(negedge clk);
        check("mid.no_restart_busy", int'(busy), 0);
        check("mid.no_restart_done", int'(done), 1);

        // asynchronous reset mid-RUN
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort.quotient", int'(quotient), 0);
        check("abort.remainder", int'(remainder), 0);
        check("abort.busy", int'(busy), 0);
        check("abort.done", int'(done), 0);
        check("abort.dbz", int'(div_by_zero), 0);
        last_q = '0;
        last_r = '0;
        @(negedge clk);
        reset_n = 1'b1;
        launch(13, 5);  finish("d13_5", 0);

        for (int a = 0; a < (1 << WIDTH); a++) begin
            for (int b = 1; b < (1 << WIDTH); b++) begin
                launch(a, b);
                finish("sweep", 0);
            end
        end

        check("sb.drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
